// File: rtl/aidc_lite_ahb_pkg.sv
// Shared AHB2 constants, slave FSM states and access helpers.
// Used by the SRAM slave and its write-strobe generator.
package aidc_lite_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  function automatic logic [3:0] calc_wstrb(
    input logic [2:0] size,
    input logic [1:0] a
  );
    logic [3:0] s;
    s = 4'b0000;
    case (size)
      HSIZE_BYTE: s = 4'b0001 << a;
      HSIZE_HALF: s = a[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: s = 4'b1111;
      default:    s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic is_misaligned(
    input logic [2:0] size,
    input logic [1:0] a
  );
    logic m;
    m = 1'b0;
    case (size)
      HSIZE_HALF: m = a[0];
      HSIZE_WORD: m = (a != 2'b00);
      default:    m = 1'b0;
    endcase
    return m;
  endfunction

  // True when any address bit at or above the byte-range width is set.
  function automatic logic out_of_range(
    input logic [31:0] a,
    input int unsigned aw
  );
    return (a >> aw) != 32'd0;
  endfunction

endpackage

// File: rtl/aidc_lite_ahb_wstrb_gen.sv
// Byte-lane strobe and misalignment decode for one AHB access.
// Ports: hsize, addr[1:0] in; wstrb[3:0], misaligned out.
module aidc_lite_ahb_wstrb_gen
  import aidc_lite_ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr,
  output logic [3:0] wstrb,
  output logic       misaligned
);

  always_comb begin
    wstrb      = calc_wstrb(hsize, addr);
    misaligned = is_misaligned(hsize, addr);
  end

endmodule

// File: rtl/aidc_lite_ahb2_sram_slave.sv
// AHB2 slave over an inline word array with wait states and ERROR.
// Ports: clk, rst_n, AHB slave inputs; hreadyout, hresp, hrdata out.
module aidc_lite_ahb2_sram_slave
  import aidc_lite_ahb_pkg::*;
#(
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready_i,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int AW = MEM_AW + 2;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

  state_t          state;
  state_t          nxt;
  logic [3:0]      cnt;
  logic [AW-1:0]   addr_q;
  logic            hwrite_q;
  logic [3:0]      wstrb_q;
  logic [3:0]      wstrb;
  logic            misalign;
  logic            accept;
  logic            illegal;
  logic            open_phase;
  logic            we;
  logic            unused;
  logic [31:0]     mem [2**MEM_AW];

  aidc_lite_ahb_wstrb_gen u_wstrb (
    .hsize      (hsize),
    .addr       (haddr[1:0]),
    .wstrb      (wstrb),
    .misaligned (misalign)
  );

  assign accept  = hsel & hready_i & htrans[1];
  assign illegal = (hsize > HSIZE_WORD) | misalign
                 | out_of_range(haddr, AW);

  // Only states that drive hreadyout high may take a new address.
  assign open_phase = (state != S_WAIT) && (state != S_ERR1);

  always_comb begin
    nxt = state;
    unique case (state)
      S_WAIT:  if (cnt == 4'd0) nxt = S_DATA;
      S_ERR1:  nxt = S_ERR2;
      default: begin
        if (!accept)
          nxt = S_IDLE;
        else if (illegal)
          nxt = S_ERR1;
        else if (WAIT_STATES > 0)
          nxt = S_WAIT;
        else
          nxt = S_DATA;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      cnt       <= 4'd0;
      addr_q    <= '0;
      hwrite_q  <= 1'b0;
      wstrb_q   <= 4'd0;
    end else begin
      state     <= nxt;
      hreadyout <= (nxt != S_WAIT) && (nxt != S_ERR1);
      hresp     <= (nxt == S_ERR1 || nxt == S_ERR2)
                 ? HRESP_ERROR : HRESP_OKAY;
      if (state != S_WAIT && nxt == S_WAIT)
        cnt <= WS_LOAD;
      else if (state == S_WAIT)
        cnt <= cnt - 4'd1;
      if (accept && open_phase) begin
        addr_q   <= haddr[AW-1:0];
        hwrite_q <= hwrite;
        wstrb_q  <= wstrb;
      end
    end
  end

  // Reset wins over a write in its final data cycle.
  assign we = rst_n && (state == S_DATA) && hwrite_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b])
          mem[addr_q[AW-1:2]][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  // Combinational read so a write committed on the previous
  // edge is seen by the following read data phase.
  assign hrdata = (state == S_DATA && !hwrite_q)
                ? mem[addr_q[AW-1:2]] : 32'd0;

  assign unused = ^{hburst, htrans[0], addr_q[1:0]};

endmodule

// File: tb/tb_aidc_lite_ahb2_sram_slave.sv
// Directed bench for the AHB2 SRAM slave.
// Two instances: zero wait states and three wait states.
module tb_aidc_lite_ahb2_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  int          tgt;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hsel0, hsel1;
  logic        rdy0, rdy1;
  logic [1:0]  resp0, resp1;
  logic [31:0] rd0, rd1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign hsel0 = sel && (tgt == 0);
  assign hsel1 = sel && (tgt == 1);

  aidc_lite_ahb2_sram_slave #(
    .MEM_AW(10), .WAIT_STATES(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel0),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hready_i(rdy0), .hreadyout(rdy0),
    .hresp(resp0), .hrdata(rd0)
  );

  aidc_lite_ahb2_sram_slave #(
    .MEM_AW(10), .WAIT_STATES(3)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel1),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hready_i(rdy1), .hreadyout(rdy1),
    .hresp(resp1), .hrdata(rd1)
  );

  function automatic logic rdy();
    return (tgt == 1) ? rdy1 : rdy0;
  endfunction

  function automatic logic [1:0] resp();
    return (tgt == 1) ? resp1 : resp0;
  endfunction

  function automatic logic [31:0] rdat();
    return (tgt == 1) ? rd1 : rd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ap(
    input logic [31:0] a,
    input logic        w,
    input logic [2:0]  s,
    input logic [1:0]  t
  );
    sel    = 1'b1;
    haddr  = a;
    hwrite = w;
    hsize  = s;
    htrans = t;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!rdy() && n < 40) begin
      n++;
      tick();
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout tgt=%0d", tgt);
    end
  endtask

  task automatic bus_write(
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [2:0]  s
  );
    int n;
    ap(a, 1'b1, s, 2'b10);
    tick();
    hwdata = d;
    htrans = 2'b00;
    wait_rdy(n);
    tick();
  endtask

  task automatic bus_read(
    input  logic [31:0] a,
    output logic [31:0] d,
    output logic        r,
    output logic [1:0]  rs
  );
    int n;
    ap(a, 1'b0, 3'd2, 2'b10);
    tick();
    htrans = 2'b00;
    wait_rdy(n);
    d  = rdat();
    r  = rdy();
    rs = resp();
    tick();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    sel    = 1'b0;
    tgt    = 0;
    haddr  = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd2;
    hburst = 3'd0;
    hwdata = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b%b exp 11", rdy0, rdy1);
    end
    checks++;
    if (resp0 !== 2'b00 || resp1 !== 2'b00) begin
      errors++;
      $display("FAIL reset_resp got %h/%h exp 0", resp0, resp1);
    end
    checks++;
    if (rd0 !== 32'd0 || rd1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata got %h/%h exp 0", rd0, rd1);
    end
  endtask

  task automatic test_word_rw();
    logic [31:0] d;
    logic r;
    logic [1:0] rs;
    tgt = 0;
    bus_write(32'h10, 32'hDEADBEEF, 3'd2);
    bus_read(32'h10, d, r, rs);
    checks++;
    if (d !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_rd got %h exp deadbeef", d);
    end
    checks++;
    if (r !== 1'b1 || rs !== 2'b00) begin
      errors++;
      $display("FAIL word_rd_rsp got %b/%h exp 1/0", r, rs);
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] d;
    logic r;
    logic [1:0] rs;
    tgt = 0;
    bus_write(32'h10, 32'h11223344, 3'd2);
    bus_write(32'h11, 32'h0000AA00, 3'd0);
    bus_read(32'h10, d, r, rs);
    checks++;
    if (d !== 32'h1122AA44) begin
      errors++;
      $display("FAIL byte_wr got %h exp 1122aa44", d);
    end
    bus_write(32'h12, 32'h55660000, 3'd1);
    bus_read(32'h10, d, r, rs);
    checks++;
    if (d !== 32'h5566AA44) begin
      errors++;
      $display("FAIL half_wr got %h exp 5566aa44", d);
    end
  endtask

  task automatic test_wait_burst();
    logic [31:0] exp_d;
    int n;
    tgt = 1;
    for (int i = 0; i < 4; i++)
      bus_write(32'h20 + 4 * i, 32'hA5A50000 + i, 3'd2);
    hburst = 3'b011;
    ap(32'h20, 1'b0, 3'd2, 2'b10);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3)
        ap(32'h24 + 4 * i, 1'b0, 3'd2, 2'b11);
      else
        htrans = 2'b00;
      wait_rdy(n);
      exp_d = 32'hA5A50000 + i;
      checks++;
      if (n != 3) begin
        errors++;
        $display("FAIL burst_wait%0d got %0d exp 3", i, n);
      end
      checks++;
      if (rd1 !== exp_d) begin
        errors++;
        $display("FAIL burst_data%0d got %h exp %h", i, rd1, exp_d);
      end
      checks++;
      if (resp1 !== 2'b00) begin
        errors++;
        $display("FAIL burst_resp%0d got %h exp 0", i, resp1);
      end
      tick();
    end
    hburst = 3'd0;
  endtask

  task automatic test_error();
    logic [31:0] ea [3];
    logic [2:0]  es [3];
    ea = '{32'h2, 32'h0, 32'h1000};
    es = '{3'd2, 3'd3, 3'd2};
    tgt = 0;
    bus_write(32'h0, 32'hCAFE0001, 3'd2);
    for (int i = 0; i < 3; i++) begin
      ap(ea[i], 1'b1, es[i], 2'b10);
      tick();
      checks++;
      if (rdy0 !== 1'b0 || resp0 !== 2'b01) begin
        errors++;
        $display("FAIL err1_%0d got %b/%h exp 0/1", i, rdy0, resp0);
      end
      hwdata = 32'hFFFFFFFF;
      htrans = 2'b00;
      tick();
      checks++;
      if (rdy0 !== 1'b1 || resp0 !== 2'b01) begin
        errors++;
        $display("FAIL err2_%0d got %b/%h exp 1/1", i, rdy0, resp0);
      end
      if (i == 2)
        ap(32'h0, 1'b0, 3'd2, 2'b10);
      tick();
    end
    htrans = 2'b00;
    checks++;
    if (rdy0 !== 1'b1 || resp0 !== 2'b00 || rd0 !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL err_after got %b/%h/%h exp 1/0/cafe0001",
               rdy0, resp0, rd0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    tgt = 0;
    bus_write(32'h40, 32'h12345678, 3'd2);
    ap(32'h40, 1'b1, 3'd2, 2'b10);
    tick();
    hwdata = 32'h1;
    ap(32'h40, 1'b0, 3'd2, 2'b10);
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wr_rdy got %b exp 1", rdy0);
    end
    tick();
    htrans = 2'b00;
    checks++;
    if (rdy0 !== 1'b1 || resp0 !== 2'b00 || rd0 !== 32'h1) begin
      errors++;
      $display("FAIL b2b_rd got %b/%h/%h exp 1/0/00000001",
               rdy0, resp0, rd0);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic r;
    logic [1:0] rs;
    tgt = 1;
    bus_write(32'h50, 32'h00005050, 3'd2);
    ap(32'h50, 1'b1, 3'd2, 2'b10);
    tick();
    hwdata = 32'hFFFFFFFF;
    htrans = 2'b00;
    rst_n  = 1'b0;
    tick();
    checks++;
    if (rdy1 !== 1'b1 || resp1 !== 2'b00 || rd1 !== 32'd0) begin
      errors++;
      $display("FAIL rst_wait got %b/%h/%h exp 1/0/0",
               rdy1, resp1, rd1);
    end
    rst_n = 1'b1;
    tick();
    tick();
    bus_read(32'h50, d, r, rs);
    checks++;
    if (d !== 32'h00005050) begin
      errors++;
      $display("FAIL rst_wait_mem got %h exp 00005050", d);
    end
    tgt = 0;
    bus_write(32'h60, 32'h00006060, 3'd2);
    ap(32'h60, 1'b1, 3'd2, 2'b10);
    tick();
    hwdata = 32'hFFFFFFFF;
    htrans = 2'b00;
    rst_n  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus_read(32'h60, d, r, rs);
    checks++;
    if (d !== 32'h00006060) begin
      errors++;
      $display("FAIL rst_data_mem got %h exp 00006060", d);
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_half();
    test_wait_burst();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
